if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the execute stage in the RISC-V core.
- Owns the architectural PC, issues requests to instruction memory over a req/gnt/rvalid handshake, and holds one fetched instruction plus its PC for decode/execute under a valid/ready handshake.
- Consumes the branch-taken flag and branch target produced by the execute stage to redirect fetch and flush wrong-path instructions.

---
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/gnt/rvalid and holds one
// instruction for execute. A taken branch redirects fetch and drops wrong-path data.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken_i,
  input  logic [31:0] pc_branch_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o
);

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        drop_q, drop_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] br_target;
  logic        gnt_now;
  logic        rsp_now;

  assign br_target = {pc_branch_i[31:2], 2'b00};

  // Request is gated by if_ready_i so a draining buffer can be refilled back to back.
  assign imem_req_o  = rst_n && (state_q == S_REQ) && (!buf_valid_q || if_ready_i);
  assign imem_addr_o = req_addr_q;
  assign if_valid_o  = buf_valid_q;
  assign if_instr_o  = buf_instr_q;
  assign if_pc_o     = buf_pc_q;

  assign gnt_now = imem_req_o && imem_gnt_i;
  assign rsp_now = (state_q == S_WAIT) && imem_rvalid_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    if (buf_valid_q && if_ready_i) buf_valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (gnt_now) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop_q) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata_i;
            buf_pc_d    = req_addr_q;
            pc_d        = req_addr_q + 32'd4;
            req_addr_d  = req_addr_q + 32'd4;
          end else begin
            // pc_q carries the redirect target while a stale fetch was in flight
            req_addr_d = pc_q;
          end
        end
      end
      default: state_d = S_REQ;
    endcase

    if (branch_taken_i) begin
      pc_d        = br_target;
      buf_valid_d = 1'b0;
      if (imem_req_o && !imem_gnt_i) begin
        // A presented request must stay stable until granted; its data is dropped later.
        drop_d = 1'b1;
      end else begin
        req_addr_d = br_target;
      end
      if (gnt_now) drop_d = 1'b1;
      if ((state_q == S_WAIT) && !imem_rvalid_i) drop_d = 1'b1;
      if (rsp_now) drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: configurable-latency memory returning addr as data,
// plus a second instance with a wrapping reset PC on a zero-wait memory.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  logic        m2_req, m2_rvalid, v2;
  logic [31:0] m2_addr, m2_rdata, instr2, pc2;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int cnt;
  int prot_err = 0;
  logic [31:0] mem_addr;
  logic outst;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .branch_taken_i(branch_taken), .pc_branch_i(pc_branch),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .if_valid_o(if_valid), .if_ready_i(if_ready), .if_instr_o(if_instr), .if_pc_o(if_pc)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .branch_taken_i(1'b0), .pc_branch_i(32'h0),
    .imem_req_o(m2_req), .imem_addr_o(m2_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(m2_rvalid), .imem_rdata_i(m2_rdata),
    .if_valid_o(v2), .if_ready_i(1'b1), .if_instr_o(instr2), .if_pc_o(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: rvalid arrives lat cycles after the grant, data = address.
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 0; imem_rvalid <= 1'b0; imem_rdata <= 32'h0; mem_addr <= 32'h0;
    end else if (imem_req && imem_gnt) begin
      mem_addr <= imem_addr;
      cnt <= lat - 1;
      imem_rvalid <= (lat == 1);
      imem_rdata <= imem_addr;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      imem_rvalid <= (cnt == 1);
      imem_rdata <= mem_addr;
    end else begin
      imem_rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m2_rvalid <= 1'b0; m2_rdata <= 32'h0;
    end else begin
      m2_rvalid <= m2_req; m2_rdata <= m2_addr;
    end
  end

  // Protocol watch: rvalid only for an outstanding request, never two outstanding.
  always @(posedge clk) begin
    if (!rst_n) outst <= 1'b0;
    else begin
      assert (!(imem_rvalid && !outst)) else begin
        $display("FAIL protocol: rvalid=%0b with no request outstanding", imem_rvalid); prot_err++;
      end
      assert (!(imem_req && outst)) else begin
        $display("FAIL protocol: req=%0b while a request is outstanding", imem_req); prot_err++;
      end
      if (imem_req && imem_gnt) outst <= 1'b1;
      else if (imem_rvalid) outst <= 1'b0;
    end
  end

  task tick; @(negedge clk); endtask

  task do_reset(input int l);
    lat = l; rst_n = 1'b0; branch_taken = 1'b0; pc_branch = 32'h0;
    if_ready = 1'b1; imem_gnt = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    #1;
  endtask

  task test_reset;
    lat = 1; rst_n = 1'b0; branch_taken = 1'b0; pc_branch = 32'h0;
    if_ready = 1'b1; imem_gnt = 1'b1;
    tick; tick;
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || if_valid !== 1'b0 ||
        if_instr !== 32'h0 || if_pc !== 32'h0) begin
      $display("FAIL reset: req=%0b addr=%h valid=%0b instr=%h pc=%h, want 0/0/0/0/0",
               imem_req, imem_addr, if_valid, if_instr, if_pc); n_fail++;
    end
    n_tests++;
    if (m2_addr !== 32'hFFFF_FFFC || v2 !== 1'b0 || m2_req !== 1'b0) begin
      $display("FAIL reset_pc_param: addr=%h valid=%0b req=%0b, want FFFFFFFC/0/0", m2_addr, v2, m2_req);
      n_fail++;
    end
  endtask

  task test_zero_wait;
    do_reset(1);
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      $display("FAIL zw_first_req: req=%0b addr=%h, want 1/0", imem_req, imem_addr); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      $display("FAIL zw_cycle2: valid=%0b req=%0b, want 0/0", if_valid, imem_req); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin
      $display("FAIL zw_beat0: valid=%0b pc=%h instr=%h addr=%h req=%0b, want 1/0/0/4/1",
               if_valid, if_pc, if_instr, imem_addr, imem_req); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b0) begin
      $display("FAIL zw_gap: valid=%0b, want 0", if_valid); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h4 || imem_addr !== 32'h8) begin
      $display("FAIL zw_beat1: valid=%0b pc=%h instr=%h addr=%h, want 1/4/4/8",
               if_valid, if_pc, if_instr, imem_addr); n_fail++;
    end
    tick; tick;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h8) begin
      $display("FAIL zw_beat2: valid=%0b pc=%h instr=%h, want 1/8/8", if_valid, if_pc, if_instr); n_fail++;
    end
  endtask

  task test_wrap;
    do_reset(1);
    tick; tick;
    n_tests++;
    if (v2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || instr2 !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_first: valid=%0b pc=%h instr=%h, want 1/FFFFFFFC/FFFFFFFC", v2, pc2, instr2); n_fail++;
    end
    tick; tick;
    n_tests++;
    if (v2 !== 1'b1 || pc2 !== 32'h0 || instr2 !== 32'h0) begin
      $display("FAIL wrap_next: valid=%0b pc=%h instr=%h, want 1/0/0", v2, pc2, instr2); n_fail++;
    end
  endtask

  task test_backpressure;
    do_reset(1);
    if_ready = 1'b0;
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_req !== 1'b0) begin
        $display("FAIL bp_hold[%0d]: valid=%0b pc=%h instr=%h req=%0b, want 1/0/0/0",
                 i, if_valid, if_pc, if_instr, imem_req); n_fail++;
      end
      if (i < 4) tick;
    end
    if_ready = 1'b1;
    #1;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      $display("FAIL bp_release_req: req=%0b addr=%h, want 1/4", imem_req, imem_addr); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b0) begin
      $display("FAIL bp_drain: valid=%0b, want 0", if_valid); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h4) begin
      $display("FAIL bp_next: valid=%0b pc=%h instr=%h, want 1/4/4", if_valid, if_pc, if_instr); n_fail++;
    end
  endtask

  task test_branch_wait;
    int k;
    logic found;
    do_reset(3);
    k = 0;
    while (!(imem_req && imem_addr == 32'h8) && k < 40) begin tick; k++; end
    n_tests++;
    if (k >= 40) begin
      $display("FAIL bw_reach_pc8: req=%0b addr=%h, want 1/8 within 40 cycles", imem_req, imem_addr); n_fail++;
    end
    tick;
    branch_taken = 1'b1; pc_branch = 32'h100;
    tick;
    branch_taken = 1'b0;
    n_tests++;
    if (if_valid !== 1'b0) begin
      $display("FAIL bw_flush: valid=%0b, want 0", if_valid); n_fail++;
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      if (if_valid) found = 1'b1;
    end
    n_tests++;
    if (!found || if_pc !== 32'h100 || if_instr !== 32'h100) begin
      $display("FAIL bw_target: found=%0b pc=%h instr=%h, want 1/100/100", found, if_pc, if_instr); n_fail++;
    end
  endtask

  task test_branch_rvalid;
    int k;
    do_reset(3);
    k = 0;
    while (!imem_rvalid && k < 20) begin tick; k++; end
    n_tests++;
    if (k >= 20) begin
      $display("FAIL br_rv_wait: rvalid=%0b, want 1 within 20 cycles", imem_rvalid); n_fail++;
    end
    branch_taken = 1'b1; pc_branch = 32'h203;
    tick;
    branch_taken = 1'b0;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      $display("FAIL br_rv_redirect: valid=%0b req=%0b addr=%h, want 0/1/200", if_valid, imem_req, imem_addr);
      n_fail++;
    end
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick;
      if (if_valid) k = i;
    end
    n_tests++;
    if (k != 4 || if_pc !== 32'h200 || if_instr !== 32'h200) begin
      $display("FAIL br_rv_no_extra_drop: cycles=%0d pc=%h instr=%h, want 4/200/200", k, if_pc, if_instr);
      n_fail++;
    end
  endtask

  task test_branch_stall;
    do_reset(1);
    tick;
    branch_taken = 1'b1; pc_branch = 32'h40; imem_gnt = 1'b0;
    tick;
    branch_taken = 1'b0;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_valid !== 1'b0) begin
      $display("FAIL bs_setup: req=%0b addr=%h valid=%0b, want 1/40/0", imem_req, imem_addr, if_valid); n_fail++;
    end
    branch_taken = 1'b1; pc_branch = 32'h80;
    tick;
    branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
        $display("FAIL bs_hold[%0d]: req=%0b addr=%h, want 1/40", i, imem_req, imem_addr); n_fail++;
      end
      if (i == 0) tick;
    end
    imem_gnt = 1'b1;
    tick;
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      $display("FAIL bs_wait: req=%0b valid=%0b, want 0/0", imem_req, if_valid); n_fail++;
    end
    tick;
    n_tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80 || if_valid !== 1'b0) begin
      $display("FAIL bs_target_req: req=%0b addr=%h valid=%0b, want 1/80/0", imem_req, imem_addr, if_valid);
      n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b0) begin
      $display("FAIL bs_no_stale: valid=%0b pc=%h, want valid 0", if_valid, if_pc); n_fail++;
    end
    tick;
    n_tests++;
    if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_instr !== 32'h80) begin
      $display("FAIL bs_target_data: valid=%0b pc=%h instr=%h, want 1/80/80", if_valid, if_pc, if_instr); n_fail++;
    end
  endtask

  task test_mid_reset;
    int k;
    do_reset(3);
    tick;
    branch_taken = 1'b1; pc_branch = 32'h300;
    tick;
    branch_taken = 1'b0;
    rst_n = 1'b0;
    tick;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      $display("FAIL mr_state: valid=%0b req=%0b addr=%h, want 0/0/0", if_valid, imem_req, imem_addr); n_fail++;
    end
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      tick;
      if (if_valid) k = i;
    end
    n_tests++;
    if (k != 4 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      $display("FAIL mr_refetch: cycles=%0d pc=%h instr=%h, want 4/0/0", k, if_pc, if_instr); n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b0; branch_taken = 1'b0; pc_branch = 32'h0; if_ready = 1'b1; imem_gnt = 1'b1;
    test_reset;
    test_zero_wait;
    test_wrap;
    test_backpressure;
    test_branch_wait;
    test_branch_rvalid;
    test_branch_stall;
    test_mid_reset;
    n_tests++;
    if (prot_err !== 0) begin
      $display("FAIL protocol_total: violations=%0d, want 0", prot_err); n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
